// File: rtl/cmul_pkg.sv
// Shared widths and the response entry for the complex-multiplier scheduler.
package cmul_pkg;
  localparam int CMUL_IN_W  = 24;
  localparam int CMUL_OUT_W = 48;
  localparam int CMUL_LAT   = 3;
  localparam int CMUL_ID_W  = 3;  // wide enough for up to 8 requesters

  typedef struct packed {
    logic [CMUL_ID_W-1:0]  id;
    logic [CMUL_OUT_W-1:0] re;
    logic [CMUL_OUT_W-1:0] im;
  } rsp_entry_t;
endpackage

// File: rtl/cmul_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer.
// The pointer moves past the winner on every grant and holds otherwise.
module cmul_rr_arb #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);
  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/cmul_share_sched.sv
// Shares one no-stall pipelined complex multiplier among NREQ requesters; accept -> rsp_valid in MUL_LAT+1 cycles.
// Credits (in-flight + buffered) cap grants at RSP_DEPTH so every product always has a response slot.
module cmul_share_sched
  import cmul_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MUL_LAT   = CMUL_LAT,
  parameter int RSP_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*CMUL_IN_W-1:0] req_a,
  input  logic [NREQ*CMUL_IN_W-1:0] req_b,
  input  logic [NREQ*CMUL_IN_W-1:0] req_c,
  input  logic [NREQ*CMUL_IN_W-1:0] req_d,
  output logic [CMUL_IN_W-1:0]      mul_a,
  output logic [CMUL_IN_W-1:0]      mul_b,
  output logic [CMUL_IN_W-1:0]      mul_c,
  output logic [CMUL_IN_W-1:0]      mul_d,
  input  logic [CMUL_OUT_W-1:0]     mul_real,
  input  logic [CMUL_OUT_W-1:0]     mul_imag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [CMUL_OUT_W-1:0]     rsp_real,
  output logic [CMUL_OUT_W-1:0]     rsp_imag
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = $clog2(RSP_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic [IDW-1:0] grant_idx;
  logic           accept, grant_en, pop, push;
  logic [CW-1:0]  outstanding, fifo_cnt;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  rsp_entry_t     fifo_mem [RSP_DEPTH];
  rsp_entry_t     head;
  logic [MUL_LAT:0] tag_vld;
  logic [IDW-1:0]   tag_id [MUL_LAT+1];

  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  // A pop in this cycle frees a credit early enough to grant alongside it.
  assign grant_en  = rst_n && ((outstanding < DEPTH_C) || pop);
  assign accept    = |req_ready;
  assign push      = tag_vld[MUL_LAT];

  cmul_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (grant_en),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      mul_c <= '0;
      mul_d <= '0;
    end else if (accept) begin
      mul_a <= req_a[grant_idx*CMUL_IN_W +: CMUL_IN_W];
      mul_b <= req_b[grant_idx*CMUL_IN_W +: CMUL_IN_W];
      mul_c <= req_c[grant_idx*CMUL_IN_W +: CMUL_IN_W];
      mul_d <= req_d[grant_idx*CMUL_IN_W +: CMUL_IN_W];
    end
  end

  // Tag pipe is one stage longer than the multiplier so capture lands on a registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int k = 0; k <= MUL_LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld   <= {tag_vld[MUL_LAT-1:0], accept};
      tag_id[0] <= grant_idx;
      for (int k = 1; k <= MUL_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{id: CMUL_ID_W'(tag_id[MUL_LAT]), re: mul_real, im: mul_imag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(RSP_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(RSP_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign head     = fifo_mem[rd_ptr];
  assign rsp_id   = rsp_valid ? IDW'(head.id) : '0;
  assign rsp_real = rsp_valid ? head.re : '0;
  assign rsp_imag = rsp_valid ? head.im : '0;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_cnt == DEPTH_C));
endmodule

// File: tb/tb_cmul_share_sched.sv
// Directed bench for cmul_share_sched with a 3-stage multiplier model and an ordered response scoreboard.
module tb_cmul_share_sched;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*24-1:0] req_a, req_b, req_c, req_d;
  logic [23:0]       mul_a, mul_b, mul_c, mul_d;
  logic [47:0]       mul_real, mul_imag;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [47:0]       rsp_real, rsp_imag;

  always #5 clk = ~clk;

  cmul_share_sched #(.NREQ(NREQ), .MUL_LAT(3), .RSP_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_real(mul_real), .mul_imag(mul_imag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_real(rsp_real), .rsp_imag(rsp_imag)
  );

  // External multiplier: result appears 3 edges after operands.
  logic [47:0] p_re [3];
  logic [47:0] p_im [3];
  always @(posedge clk) begin
    p_re[0] <= 48'(mul_a) * 48'(mul_c) - 48'(mul_b) * 48'(mul_d);
    p_im[0] <= 48'(mul_a) * 48'(mul_d) + 48'(mul_b) * 48'(mul_c);
    p_re[1] <= p_re[0];
    p_im[1] <= p_im[0];
    p_re[2] <= p_re[1];
    p_im[2] <= p_im[1];
  end
  assign mul_real = p_re[2];
  assign mul_imag = p_im[2];

  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] re;
    logic [47:0] im;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;
  logic [23:0] oa [NREQ];
  logic [23:0] ob [NREQ];
  logic [23:0] oc [NREQ];
  logic [23:0] od [NREQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int p);
    logic [3:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic set_ops();
    for (int p = 0; p < NREQ; p++) begin
      oa[p] = 24'(100 + p);
      ob[p] = 24'(2000 * p + 1);
      oc[p] = 24'(300 + p);
      od[p] = 24'(7 * p + 5);
      req_a[24*p +: 24] = oa[p];
      req_b[24*p +: 24] = ob[p];
      req_c[24*p +: 24] = oc[p];
      req_d[24*p +: 24] = od[p];
    end
  endtask

  task automatic push_exp(input int p);
    exp_t e;
    e.id = 2'(p);
    e.re = 48'(oa[p]) * 48'(oc[p]) - 48'(ob[p]) * 48'(od[p]);
    e.im = 48'(oa[p]) * 48'(od[p]) + 48'(ob[p]) * 48'(oc[p]);
    exp_q.push_back(e);
  endtask

  task automatic chk_rsp();
    exp_t e;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_extra", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_real", 64'(rsp_real), 64'(e.re));
        chk("rsp_imag", 64'(rsp_imag), 64'(e.im));
        rsp_seen++;
      end
    end
  endtask

  // Drive one lone request and check its grant, latency and result.
  task automatic single(input int port, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] c, input logic [23:0] d,
                        input logic [47:0] ere, input logic [47:0] eim);
    int lat;
    @(negedge clk);
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    req_a[24*port +: 24] = a;
    req_b[24*port +: 24] = b;
    req_c[24*port +: 24] = c;
    req_d[24*port +: 24] = d;
    req_valid = onehot(port);
    rsp_ready = 1'b0;
    #1 chk("s_grant", 64'(req_ready), 64'(onehot(port)));
    @(negedge clk);
    req_valid = '0;
    chk("s_mul_a", 64'(mul_a), 64'(a));
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("s_latency", 64'(lat), 64'd4);
    chk("s_id", 64'(rsp_id), 64'(port));
    chk("s_real", 64'(rsp_real), 64'(ere));
    chk("s_imag", 64'(rsp_imag), 64'(eim));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("s_popped", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    int stale;
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0;
    @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_real", 64'(rsp_real), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single port 2: ac<bd wraps the real part. Pointer 0 -> 3 afterwards.
    single(2, 24'd3, 24'd4, 24'd5, 24'd6, 48'hFFFF_FFFF_FFF7, 48'd38);
    // Max operands on port 0. Pointer 3 -> 1 afterwards.
    single(0, 24'hFFFFFF, 24'd0, 24'hFFFFFF, 24'd0, 48'hFFFF_FE00_0001, 48'd0);

    // All valid, consumer always ready: one grant per cycle rotating from port 1.
    set_ops();
    rsp_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ready = 1'b1;
      #1 chk_rsp();
      chk("t2_grant", 64'(req_ready), 64'(onehot((1 + k) % 4)));
      push_exp((1 + k) % 4);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1 chk_rsp();
    end
    chk("t2_count", 64'(rsp_seen), 64'd8);

    // Consumer stalled: exactly 8 accepts, then grants stop. Pointer back at 1.
    rsp_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ready = 1'b0;
      #1;
      if (k < 8) begin
        chk("t3_grant", 64'(req_ready), 64'(onehot((1 + k) % 4)));
        push_exp((1 + k) % 4);
      end else begin
        chk("t3_full", 64'(req_ready), 64'd0);
      end
    end

    // Credits exhausted: the pop itself lets a grant through in the same cycle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ready = 1'b1;
      #1 chk_rsp();
      chk("t4_grant", 64'(req_ready), 64'(onehot((1 + k) % 4)));
      push_exp((1 + k) % 4);
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1 chk_rsp();
    end
    chk("t34_count", 64'(rsp_seen), 64'd14);
    chk("t34_left", 64'(exp_q.size()), 64'd0);

    // Five accepts from pointer 3, then reset with 2 buffered and 3 in flight.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = '1;
      rsp_ready = 1'b0;
      #1 chk("t6_grant", 64'(req_ready), 64'(onehot((3 + k) % 4)));
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("t6_buffered", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(rsp_valid), 64'd0);
    chk("t6_rst_id", 64'(rsp_id), 64'd0);
    chk("t6_rst_real", 64'(rsp_real), 64'd0);
    chk("t6_rst_imag", 64'(rsp_imag), 64'd0);
    chk("t6_rst_mul_a", 64'(mul_a), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    exp_q.delete();
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("t6_stale", 64'(stale), 64'd0);
    rsp_ready = 1'b0;

    // Fresh pointer after reset; port 1 alone.
    single(1, 24'd10, 24'd2, 24'd7, 24'd1, 48'd68, 48'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
